// File: rtl/uart_rx_deserializer_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_deserializer_if
//  Brief    : Byte handshake between the UART receiver and the RxD byte port.
//  Revision : 1.0  initial release
// ============================================================================
interface uart_rx_deserializer_if;
    logic [7:0] RxD_din;
    logic       RxD_wr;
    logic       RxD_ready;

    modport master (output RxD_din, output RxD_wr, input RxD_ready);
    modport slave  (input RxD_din, input RxD_wr, output RxD_ready);
endinterface
`default_nettype wire

// File: rtl/uart_rx_deserializer.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_deserializer
//  Brief    : 8N1 UART receiver feeding a one-byte valid/ready holding register.
//             Define UART_RX_PARITY_EN to add a parity bit and live parity_err.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_deserializer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY_ODD   = 0
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               rxd,
    uart_rx_deserializer_if.master  rx_if,
    output logic                    framing_err,
    output logic                    overrun_err,
    output logic                    parity_err
);

    localparam int                 c_CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_HALF_M1 = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_LAST    = c_CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY    = 3'd3,
`endif
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [1:0]         r_sync;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]         r_bit_idx, w_bit_idx_nxt;
    logic [7:0]         r_shift, w_shift_nxt;
    logic [7:0]         r_din, w_din_nxt;
    logic               r_wr, w_wr_nxt;
    logic               r_ferr, w_ferr_nxt;
    logic               r_oerr, w_oerr_nxt;
    logic               w_commit;
    logic               w_rs;
`ifdef UART_RX_PARITY_EN
    localparam logic    c_PAR_ODD = (PARITY_ODD != 0);
    logic               r_perr, w_perr_nxt;
    logic               r_perr_pulse, w_perr_pulse_nxt;
`endif

    assign w_rs = r_sync[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rxd};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_din     <= '0;
            r_wr      <= 1'b0;
            r_ferr    <= 1'b0;
            r_oerr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr       <= 1'b0;
            r_perr_pulse <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_din     <= w_din_nxt;
            r_wr      <= w_wr_nxt;
            r_ferr    <= w_ferr_nxt;
            r_oerr    <= w_oerr_nxt;
`ifdef UART_RX_PARITY_EN
            r_perr       <= w_perr_nxt;
            r_perr_pulse <= w_perr_pulse_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_din_nxt     = r_din;
        w_wr_nxt      = r_wr & ~rx_if.RxD_ready;
        w_ferr_nxt    = 1'b0;
        w_oerr_nxt    = 1'b0;
        w_commit      = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_perr_nxt       = r_perr;
        w_perr_pulse_nxt = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (!w_rs) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_START;
`ifdef UART_RX_PARITY_EN
                    w_perr_nxt  = 1'b0;
`endif
                end
            end
            S_START: begin
                if (r_cnt == c_HALF_M1) begin
                    w_cnt_nxt     = '0;
                    w_bit_idx_nxt = '0;
                    // A start bit that is high again at mid-bit is a glitch.
                    w_state_nxt   = w_rs ? S_IDLE : S_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            S_DATA: begin
                if (r_cnt == c_LAST) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {w_rs, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (r_cnt == c_LAST) begin
                    w_cnt_nxt   = '0;
                    w_perr_nxt  = (^r_shift) ^ w_rs ^ c_PAR_ODD;
                    w_state_nxt = S_STOP;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (r_cnt == c_LAST) begin
                    w_cnt_nxt = '0;
`ifdef UART_RX_PARITY_EN
                    w_commit         = w_rs & ~r_perr;
                    w_perr_pulse_nxt = r_perr;
`else
                    w_commit         = w_rs;
`endif
                    w_ferr_nxt  = ~w_rs;
                    w_state_nxt = w_rs ? S_IDLE : S_WAIT_HIGH;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            S_WAIT_HIGH: begin
                if (w_rs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // A byte being drained this cycle frees the register for the new one.
        if (w_commit) begin
            if (!r_wr || rx_if.RxD_ready) begin
                w_din_nxt = r_shift;
                w_wr_nxt  = 1'b1;
            end else begin
                w_oerr_nxt = 1'b1;
            end
        end
    end

    assign rx_if.RxD_din = r_din;
    assign rx_if.RxD_wr  = r_wr;
    assign framing_err   = r_ferr;
    assign overrun_err   = r_oerr;
`ifdef UART_RX_PARITY_EN
    assign parity_err    = r_perr_pulse;
`else
    assign parity_err    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deserializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_deserializer
//  Brief    : Scoreboard bench for uart_rx_deserializer at CLKS_PER_BIT = 8.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_deserializer;

    localparam int C = 8;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 87;
`else
    localparam int LAT = 79;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic rxd = 1'b1;
    logic framing_err, overrun_err, parity_err;

    uart_rx_deserializer_if rif ();

    uart_rx_deserializer #(.CLKS_PER_BIT(C), .PARITY_ODD(0)) dut (
        .clk         (clk),
        .reset       (reset),
        .rxd         (rxd),
        .rx_if       (rif.master),
        .framing_err (framing_err),
        .overrun_err (overrun_err),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    int n_ferr = 0;
    int n_oerr = 0;
    int n_perr = 0;
    int first_wr_cyc = -1;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted byte and counts pulses.
    initial begin
        logic wr_prev;
        logic [7:0] exp_b;
        wr_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (rif.RxD_wr && !wr_prev) first_wr_cyc = cyc;
                wr_prev = rif.RxD_wr;
                if (rif.RxD_wr && rif.RxD_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_byte: got %0h expected none", rif.RxD_din);
                    end else begin
                        exp_b = exp_q.pop_front();
                        check("rx_byte", {24'd0, rif.RxD_din}, {24'd0, exp_b});
                    end
                end
                if (framing_err) n_ferr++;
                if (overrun_err) n_oerr++;
                if (parity_err)  n_perr++;
            end else begin
                wr_prev = 1'b0;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_period(input logic v);
        rxd = v;
        repeat (C) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
        bit_period(1'b0);
        for (int i = 0; i < 8; i++) bit_period(d[i]);
`ifdef UART_RX_PARITY_EN
        bit_period(par);
`else
        if (par === 1'bx) rxd = 1'b1;
`endif
        bit_period(stop);
    endtask

    task automatic send(input logic [7:0] d);
        send_frame(d, 1'b1, ^d);
    endtask

    initial begin
        int fall;
        rif.RxD_ready = 1'b1;
        idle(3);
        check("reset_wr", {31'd0, rif.RxD_wr}, 32'd0);
        check("reset_din", {24'd0, rif.RxD_din}, 32'd0);
        check("reset_ferr", {31'd0, framing_err}, 32'd0);
        check("reset_oerr", {31'd0, overrun_err}, 32'd0);
        check("reset_perr", {31'd0, parity_err}, 32'd0);
        reset = 1'b1;
        idle(5);

        // Basic receive with latency and single-cycle valid
        fall = cyc;
        exp_q.push_back(8'h55);
        send(8'h55);
        check("basic_latency", first_wr_cyc, fall + LAT);
        @(negedge clk);
        check("basic_wr_pulse", {31'd0, rif.RxD_wr}, 32'd0);
        @(posedge clk);
        #1;
        idle(10);
        check("basic_no_errs", n_ferr + n_oerr + n_perr, 32'd0);

        // Start glitch
        rxd = 1'b0;
        idle(2);
        rxd = 1'b1;
        idle(30);
        check("glitch_wr", {31'd0, rif.RxD_wr}, 32'd0);
        check("glitch_ferr", n_ferr, 32'd0);

        // Framing error followed by a break
        send_frame(8'hA3, 1'b0, ^8'hA3);
        rxd = 1'b0;
        idle(40);
        rxd = 1'b1;
        idle(20);
        check("framing_count", n_ferr, 32'd1);
        check("framing_wr", {31'd0, rif.RxD_wr}, 32'd0);
        exp_q.push_back(8'h3C);
        send(8'h3C);
        idle(10);

        // Overrun with back-to-back frames
        rif.RxD_ready = 1'b0;
        exp_q.push_back(8'h11);
        send(8'h11);
        send(8'h22);
        idle(5);
        check("overrun_count", n_oerr, 32'd1);
        check("overrun_wr_held", {31'd0, rif.RxD_wr}, 32'd1);
        check("overrun_din_kept", {24'd0, rif.RxD_din}, 32'h11);
        rif.RxD_ready = 1'b1;
        idle(2);
        check("overrun_drained", {31'd0, rif.RxD_wr}, 32'd0);
        idle(10);

        // Reset mid-frame while a byte is held
        rif.RxD_ready = 1'b0;
        send(8'h5A);
        idle(3);
        check("hold_wr", {31'd0, rif.RxD_wr}, 32'd1);
        check("hold_din", {24'd0, rif.RxD_din}, 32'h5A);
        bit_period(1'b0);
        for (int i = 0; i < 4; i++) bit_period(1'b1);
        idle(3);
        #2 reset = 1'b0;
        #1;
        check("midrst_wr", {31'd0, rif.RxD_wr}, 32'd0);
        check("midrst_din", {24'd0, rif.RxD_din}, 32'd0);
        check("midrst_errs", {29'd0, framing_err, overrun_err, parity_err}, 32'd0);
        idle(2);
        reset = 1'b1;
        rif.RxD_ready = 1'b1;
        idle(20);
        exp_q.push_back(8'h80);
        send(8'h80);
        idle(10);

`ifdef UART_RX_PARITY_EN
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        idle(5);
        send_frame(8'h07, 1'b1, 1'b0);
        idle(10);
        check("parity_count", n_perr, 32'd1);
`else
        check("parity_count", n_perr, 32'd0);
`endif
        check("final_ferr", n_ferr, 32'd1);
        check("final_oerr", n_oerr, 32'd1);

        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

Synthesizable serial UART receiver that turns an asynchronous 8N1 line into bytes and pushes them into the RxD byte port of the simulator/JTAG UART peripheral (`RxD_din` / `RxD_wr` / `RxD_ready`). It replaces the testbench stdin driver on hardware, so the peripheral's receive FIFO is fed from a real pin. It has a single-byte holding register with a valid/ready handshake and reports framing and overrun errors as one-cycle pulses.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per bit, e.g. 50 MHz / 115200. Legal range is >= 4.
- `PARITY_ODD`, default 0: 0 = even parity, 1 = odd parity. Used only when `UART_RX_PARITY_EN` is defined.

- `clk`  in  1: the block's only clock.
- `reset`  in  1: asynchronous, active-low reset.
- `rxd`  in  1: serial line, asynchronous to `clk`, idle high.
- `RxD_din`  out  8: received byte.
- `RxD_wr`  out  1: holding register valid.
- `RxD_ready`  in  1: consumer can accept a byte.
- `framing_err`  out  1: one-cycle pulse when the stop bit is sampled low.
- `overrun_err`  out  1: one-cycle pulse when a good byte is dropped.
- `parity_err`  out  1: one-cycle pulse on parity mismatch.

## Operation
- **Synchronizer:** `rxd` passes through 2 flops that reset to 1. `rs` is the synchronized value.
- **Bit counter:** `cnt` is log2(CLKS_PER_BIT) bits wide. `bit_idx` is 3 bits. `HALF` = floor(CLKS_PER_BIT/2).
- **IDLE:** when `rs`==0, clear `cnt` and go to START.
- **START:** when `cnt`==HALF-1, sample `rs`.
  - `rs`==0: clear `cnt` and `bit_idx`, go to DATA.
  - `rs`==1: treat as a glitch, go to IDLE. No pulse.
- **DATA:** every CLKS_PER_BIT cycles, shift `rs` into the shift register at bit 7. This gives LSB-first order.
  - After bit 7, go to PARITY (macro defined) or STOP (macro not defined).
- **PARITY:** sample one bit after CLKS_PER_BIT cycles and go to STOP. Set the internal `perr` flag if (^data ^ bit ^ PARITY_ODD) != 0.
- **STOP:** sample after CLKS_PER_BIT cycles.
  - `rs`==1 and no `perr`: commit the byte, go to IDLE.
  - `rs`==1 and `perr`: pulse `parity_err`, discard the byte, go to IDLE.
  - `rs`==0: pulse `framing_err`, discard the byte, go to WAIT_HIGH. If `perr` is also set, `parity_err` pulses too.
- **WAIT_HIGH:** stay until `rs`==1, then go to IDLE. Break conditions therefore produce exactly one `framing_err`.
- **Commit:**
  - If the holding register is empty, or is being drained this cycle (`RxD_wr & RxD_ready`), load `RxD_din` and set `RxD_wr`.
  - Otherwise drop the new byte, pulse `overrun_err`, and keep the old byte.
- **Handshake:**
  - The byte is transferred on any cycle with `RxD_wr & RxD_ready`.
  - `RxD_wr` clears on the next edge unless a commit happens in the same cycle, in which case it stays 1 with the new byte.
  - `RxD_din` is stable while `RxD_wr`=1.
- **Reset mid-frame:** the state returns to IDLE, the partial byte is discarded, and the holding register is cleared.

## Timing
- **Reset values:** `RxD_din`=0, `RxD_wr`=0, `framing_err`=0, `overrun_err`=0, `parity_err`=0, state=IDLE, sync flops=1.
- **Start detection:** t0 is the first cycle IDLE sees `rs`==0, which is 2–3 cycles after the `rxd` fall.
- **Sample points:**
  - Start bit: t0+HALF.
  - Data bit i (i=0..7): t0+HALF+(i+1)·CLKS_PER_BIT.
  - Parity bit: t0+HALF+9·CLKS_PER_BIT.
  - Stop bit: t0+HALF+9·CLKS_PER_BIT without parity, +10·CLKS_PER_BIT with parity.
- **Output latency:** `RxD_wr` and the error pulses are registered. They assert on the edge after the stop sample and last exactly 1 cycle, except `RxD_wr`, which holds until accepted.
- **Back-to-back frames:** a new start edge is accepted in IDLE the cycle after STOP. Back-to-back frames with one stop bit are received without loss.

## Configuration
- **`UART_RX_PARITY_EN` defined:** the PARITY state is compiled in, frames are 8 data + 1 parity + 1 stop, and `parity_err` is live.
- **`UART_RX_PARITY_EN` undefined:** frames are 8N1, the PARITY state and `perr` logic are absent, and `parity_err` is tied to 0.

## Test plan
- **Basic receive:** CLKS_PER_BIT=8, `RxD_ready`=1, send 0x55 -> `RxD_din`=0x55 with `RxD_wr` high for 1 cycle, at t0+4+72+1. All error outputs stay 0.
- **Start glitch:** `rxd` low for 2 cycles, then high (CLKS_PER_BIT=8) -> no `RxD_wr`, no error pulse; state back in IDLE.
- **Framing/break:** send 0xA3 with the stop bit low, then hold `rxd` low for 40 cycles -> exactly one `framing_err` pulse, no `RxD_wr`; then 0x3C sent after `rxd` returns high is received correctly.
- **Overrun:** `RxD_ready`=0, send 0x11 then 0x22 -> `RxD_wr`=1 with 0x11, and one `overrun_err` pulse at the 0x22 stop sample. Raising `RxD_ready` then drains 0x11 and `RxD_wr` drops.
- **Reset mid-frame:** assert `reset` low at data bit 4 of 0xFF -> all outputs 0 immediately. After release, 0x80 is received cleanly.
- **Parity (`UART_RX_PARITY_EN` defined, `PARITY_ODD`=0):**
  - Send 0x07 with parity bit 1 -> byte delivered, no error.
  - Send 0x07 with parity bit 0 -> one `parity_err` pulse, no `RxD_wr`.
